// File: rtl/dcache_wb_buffer.sv
// Victim write buffer between the data cache and the AXI bridge.
// Dirty line evictions are queued in a DEPTH-entry FIFO and drained one
// line at a time to the bridge. Refill reads pass through to the bridge,
// unless the line is still queued, being queued this cycle, or was the last
// line retired. In those cases the read is served from the buffer.
module dcache_wb_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LINE_W    = 512,
    parameter int unsigned OFF_W     = 6,
    parameter int unsigned BURST_LEN = 15
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       c_waddr,
    input  logic [LINE_W-1:0] c_wdata,
    input  logic              c_wvalid,
    output logic              c_wready,
    input  logic [31:0]       c_raddr,
    input  logic              c_rvalid,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_rready,
    output logic [31:0]       d_waddr,
    output logic [LINE_W-1:0] d_wdata,
    output logic              d_wvalid,
    input  logic              d_wready,
    output logic [7:0]        d_wlen,
    output logic [3:0]        d_wstrb,
    output logic [31:0]       d_raddr,
    output logic              d_rvalid,
    input  logic [LINE_W-1:0] d_rdata,
    input  logic              d_rready,
    output logic [7:0]        d_rlen,
    output logic              wb_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = 32 - OFF_W;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_MISS = 2'd2
    } rstate_e;

    // FIFO storage. The data arrays are not reset; validity comes from count.
    logic [31:0]       addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // The retire slot keeps the last drained line. It is readable while that
    // line's write response may still be in flight.
    logic              ret_vld_q;
    logic [TAG_W-1:0]  ret_tag_q;
    logic [LINE_W-1:0] ret_data_q;

    // Read path
    rstate_e           rstate_q;
    logic [31:0]       raddr_q;
    logic [LINE_W-1:0] rline_q;

    logic              enq_s;
    logic              deq_s;
    logic              hit_s;
    logic [LINE_W-1:0] hit_data_s;
    logic [PTR_W-1:0]  idx_s;

    assign c_wready = (count_q != CNT_W'(DEPTH));
    assign d_wvalid = (count_q != {CNT_W{1'b0}});
    assign enq_s    = c_wvalid & c_wready;
    assign deq_s    = d_wready & d_wvalid;

    // The head entry is presented only while the FIFO holds a line.
    assign d_waddr  = d_wvalid ? addr_q[rd_ptr_q] : 32'h0;
    assign d_wdata  = d_wvalid ? data_q[rd_ptr_q] : {LINE_W{1'b0}};
    assign d_wlen   = 8'(BURST_LEN);
    assign d_wstrb  = 4'hF;
    assign d_rlen   = 8'(BURST_LEN);
    assign d_raddr  = raddr_q;
    assign d_rvalid = (rstate_q == R_MISS);
    assign wb_empty = (count_q == {CNT_W{1'b0}}) && (rstate_q == R_IDLE);

    // Refill response: latched line on a forward, or bridge data passed straight through on a miss
    always_comb begin
        c_rready = 1'b0;
        c_rdata  = {LINE_W{1'b0}};
        if (rstate_q == R_FWD) begin
            c_rready = 1'b1;
            c_rdata  = rline_q;
        end else if ((rstate_q == R_MISS) && d_rready) begin
            c_rready = 1'b1;
            c_rdata  = d_rdata;
        end else begin
            c_rready = 1'b0;
            c_rdata  = {LINE_W{1'b0}};
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Refill lookup. Sources are scanned from oldest to youngest so the youngest match overwrites the others.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {LINE_W{1'b0}};
        idx_s      = {PTR_W{1'b0}};
        if (ret_vld_q && (ret_tag_q == c_raddr[31:OFF_W])) begin
            hit_s      = 1'b1;
            hit_data_s = ret_data_q;
        end else begin
            hit_s      = 1'b0;
        end
        // Age i counts back from wr_ptr-1. Only the count_q youngest slots hold lines.
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            idx_s = wr_ptr_q - PTR_W'(i + 1);
            if ((CNT_W'(i) < count_q) && (addr_q[idx_s][31:OFF_W] == c_raddr[31:OFF_W])) begin
                hit_s      = 1'b1;
                hit_data_s = data_q[idx_s];
            end else begin
                hit_s      = hit_s;
            end
        end
        if (enq_s && (c_waddr[31:OFF_W] == c_raddr[31:OFF_W])) begin
            hit_s      = 1'b1;
            hit_data_s = c_wdata;
        end else begin
            hit_s      = hit_s;
        end
    end

    // FIFO line storage written on enqueue
    always_ff @(posedge aclk) begin
        if (enq_s) begin
            addr_q[wr_ptr_q] <= c_waddr;
            data_q[wr_ptr_q] <= c_wdata;
        end
    end

    // Pointers, occupancy and retire slot
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            ret_vld_q  <= 1'b0;
            ret_tag_q  <= {TAG_W{1'b0}};
            ret_data_q <= {LINE_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (deq_s) begin
                ret_vld_q  <= 1'b1;
                ret_tag_q  <= addr_q[rd_ptr_q][31:OFF_W];
                ret_data_q <= data_q[rd_ptr_q];
            end
        end
    end

    // Read FSM: one lookup per request, then forward from the buffer or wait on the bridge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q <= R_IDLE;
            raddr_q  <= 32'h0;
            rline_q  <= {LINE_W{1'b0}};
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (c_rvalid) begin
                        raddr_q <= c_raddr;
                        if (hit_s) begin
                            rline_q  <= hit_data_s;
                            rstate_q <= R_FWD;
                        end else begin
                            rstate_q <= R_MISS;
                        end
                    end
                end
                R_FWD: begin
                    rstate_q <= R_IDLE;
                end
                R_MISS: begin
                    if (d_rready) begin
                        rstate_q <= R_IDLE;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

endmodule
